// File: rtl/csr_trap_seq_ysyx_23060136.sv
// csr_trap_seq_ysyx_23060136
//   Machine-mode CSR file with an ECALL/MRET trap sequencer. One request is
//   handled at a time: IDLE -> EXEC -> (TRAP2 for ECALL) -> RESP -> IDLE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The producer holds valid and its payload stable until that
//   edge. req_ready is high only in IDLE. resp_valid is high only in RESP.
//   The response payload (resp_rdata, resp_err, redirect_valid, redirect_pc)
//   is held stable until resp_ready is seen.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_op                       0 CSRRW, 1 CSRRS, 2 CSRRC, 4 ECALL, 5 MRET
//   req_csr_id, req_wdata        CSR address and source operand
//   req_pc                       PC of the requesting instruction
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         old CSR value / error flag
//   redirect_valid, redirect_pc  PC change request (only with resp_valid)
//   dbg_state                    current FSM state, for debug visibility
module csr_trap_seq_ysyx_23060136 #(
   parameter logic [31:0] MVENDORID = 32'h7973_7978,
   parameter logic [31:0] MARCHID   = 32'h015F_DEA8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [11:0] req_csr_id,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_TRAP2, S_RESP} state_t;

   localparam logic [2:0] OP_RW = 3'd0, OP_RS = 3'd1, OP_RC = 3'd2,
                          OP_ECALL = 3'd4, OP_MRET = 3'd5;

   localparam logic [11:0] A_MSTATUS = 12'h300, A_MTVEC = 12'h305,
                           A_MEPC = 12'h341, A_MCAUSE = 12'h342,
                           A_MVENDORID = 12'hF11, A_MARCHID = 12'hF12;

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [11:0] csr_q;
   logic [31:0] wdata_q, pc_q;
   logic [31:0] mstatus, mtvec, mepc, mcause;
   logic        redir_q;

   // Decode of the latched request, used only in EXEC.
   logic        is_csr_op, csr_known, csr_ro, csr_wr_req, csr_we, op_err;
   logic [31:0] old_val, new_val;

   always_comb begin
      old_val   = 32'h0;
      csr_known = 1'b1;
      csr_ro    = 1'b0;
      case (csr_q)
         A_MSTATUS:   old_val = mstatus;
         A_MTVEC:     old_val = mtvec;
         A_MEPC:      old_val = mepc;
         A_MCAUSE:    old_val = mcause;
         A_MVENDORID: begin old_val = MVENDORID; csr_ro = 1'b1; end
         A_MARCHID:   begin old_val = MARCHID;   csr_ro = 1'b1; end
         default:     csr_known = 1'b0;
      endcase

      is_csr_op  = (op_q == OP_RW) || (op_q == OP_RS) || (op_q == OP_RC);
      // RS/RC with a zero operand is a pure read, even of read-only CSRs.
      csr_wr_req = (op_q == OP_RW) || (wdata_q != 32'h0);
      csr_we     = is_csr_op && csr_known && !csr_ro && csr_wr_req;
      op_err     = is_csr_op ? (!csr_known || (csr_ro && csr_wr_req))
                             : !((op_q == OP_ECALL) || (op_q == OP_MRET));

      case (op_q)
         OP_RW:   new_val = wdata_q;
         OP_RS:   new_val = old_val | wdata_q;
         default: new_val = old_val & ~wdata_q;
      endcase
      // Trap vector and return address are always word aligned.
      if (csr_q == A_MTVEC || csr_q == A_MEPC) new_val[1:0] = 2'b00;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = (op_q == OP_ECALL) ? S_TRAP2 : S_RESP;
         S_TRAP2: state_nxt = S_RESP;
         S_RESP:  if (resp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request latch, CSR state and registered response payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= 3'd0;
         csr_q       <= 12'h0;
         wdata_q     <= 32'h0;
         pc_q        <= 32'h0;
         mstatus     <= 32'h0000_1800;
         mtvec       <= 32'h0;
         mepc        <= 32'h0;
         mcause      <= 32'h0;
         resp_rdata  <= 32'h0;
         resp_err    <= 1'b0;
         redir_q     <= 1'b0;
         redirect_pc <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q        <= req_op;
                  csr_q       <= req_csr_id;
                  wdata_q     <= req_wdata;
                  pc_q        <= req_pc;
                  resp_rdata  <= 32'h0;
                  resp_err    <= 1'b0;
                  redir_q     <= 1'b0;
                  redirect_pc <= 32'h0;
               end
            end
            S_EXEC: begin
               if (is_csr_op) begin
                  resp_err   <= op_err;
                  resp_rdata <= op_err ? 32'h0 : old_val;
                  if (csr_we) begin
                     case (csr_q)
                        A_MSTATUS: mstatus <= new_val;
                        A_MTVEC:   mtvec   <= new_val;
                        A_MEPC:    mepc    <= new_val;
                        A_MCAUSE:  mcause  <= new_val;
                        default:   ;
                     endcase
                  end
               end else if (op_q == OP_ECALL) begin
                  mepc   <= {pc_q[31:2], 2'b00};
                  mcause <= 32'd11;
               end else if (op_q == OP_MRET) begin
                  mstatus[3]     <= mstatus[7];
                  mstatus[7]     <= 1'b1;
                  mstatus[12:11] <= 2'b11;
                  redirect_pc    <= mepc;
                  redir_q        <= 1'b1;
               end else begin
                  resp_err <= 1'b1;
               end
            end
            S_TRAP2: begin
               mstatus[7]     <= mstatus[3];
               mstatus[3]     <= 1'b0;
               mstatus[12:11] <= 2'b11;
               redirect_pc    <= mtvec;
               redir_q        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req_ready      = (state == S_IDLE);
   assign resp_valid     = (state == S_RESP);
   // Gated so a redirect can never be seen without its response.
   assign redirect_valid = redir_q && (state == S_RESP);
   assign dbg_state      = state;

endmodule
